pipe_ctrl: RTL
==============

Name: pipe_ctrl

Overview:
- Central hazard and flush scheduler for the in-order RISC-V pipeline (pc_reg → if_id → id → id_ex → ex → writeback).
- Takes redirect requests from ex, external hold requests from the bus, and decoded register addresses from id.
- Drives pc redirect plus hold/flush controls for pc_reg, if_id and id_ex.
- Tracks in-flight destination registers in a scoreboard to stall read-after-write hazards; the pipeline has no forwarding.

Parameters:
- SB_DEPTH, 2, number of stages between id issue and register-file write; equals the scoreboard entry count.
- FLUSH_EXTRA, 1, extra flush cycles after the redirect cycle; covers the synchronous instruction-ROM fetch latency.
- CNT_W, 32, width of the performance counters.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- jump_en  in  1  redirect request from ex.
- jump_addr  in  32  redirect target from ex.
- ext_hold  in  1  bus/external freeze request.
- id_rs1_addr  in  5  rs1 index decoded by id; 0 means unused.
- id_rs2_addr  in  5  rs2 index decoded by id; 0 means unused.
- id_rd_addr  in  5  rd index decoded by id.
- id_rd_wen  in  1  id instruction writes rd.
- jump_en_o  out  1  redirect to pc_reg.
- jump_addr_o  out  32  redirect target to pc_reg.
- hold_pc  out  1  pc_reg keeps its value.
- hold_if_id  out  1  if_id keeps its contents.
- hold_id_ex  out  1  id_ex keeps its contents.
- flush_if_id  out  1  if_id loads a NOP (0x00000013).
- flush_id_ex  out  1  id_ex loads a bubble (NOP, rd_wen=0).
- stall_cnt  out  CNT_W  count of RAW-stall cycles.
- flush_cnt  out  CNT_W  count of cycles with flush_id_ex high due to redirect.

Behaviour:
- Control outputs are combinational from state, scoreboard and inputs; state, scoreboard and counters are registered.
- Reset (async, immediate): state=RUN, flush counter=0, all scoreboard entries invalid, stall_cnt=0, flush_cnt=0. With inputs idle, all control outputs read 0 and jump_addr_o=0.
- States: RUN, FLUSH.
- Priority each cycle: ext_hold > jump_en > FLUSH > RAW stall > normal.
- ext_hold=1:
  - hold_pc=hold_if_id=hold_id_ex=1; all flush outputs and jump_en_o are 0.
  - State, flush counter, scoreboard and counters are frozen.
  - jump_en is ignored; ex stays frozen and re-presents it.
- jump_en=1 (no ext_hold):
  - jump_en_o=1, jump_addr_o=jump_addr; flush_if_id=flush_id_ex=1; holds 0.
  - If FLUSH_EXTRA>0: next state FLUSH, counter loads FLUSH_EXTRA. If FLUSH_EXTRA=0: stay in RUN.
  - Accepted in FLUSH as well; the counter reloads. flush_cnt increments.
- FLUSH, no jump:
  - flush_if_id=flush_id_ex=1; counter decrements; flush_cnt increments.
  - When the counter reaches 0 (after FLUSH_EXTRA cycles in FLUSH), next state is RUN.
  - No RAW stall is evaluated in FLUSH.
- RAW hazard in RUN: a source index is nonzero and equals the rd of any valid scoreboard entry.
  - Response: hold_pc=hold_if_id=1, flush_id_ex=1; stall_cnt increments.
  - Persists each cycle until the matching entry retires.
- jump_addr_o equals jump_addr when jump_en_o=1, otherwise 0.
- Scoreboard: shift register of SB_DEPTH {valid, rd} entries.
  - Shifts every non-ext_hold cycle; the oldest entry retires.
  - Entry 0 loads valid=1, rd=id_rd_addr only when id_rd_wen=1, id_rd_addr≠0 and flush_id_ex=0 that cycle. Otherwise entry 0 loads invalid.
  - A write in the retiring stage is visible to id the cycle after retirement.
- Counters wrap modulo 2^CNT_W.
- Mid-operation reset: immediately returns to RUN with an empty scoreboard; any pending flush is abandoned.

Test Plan:
- Reset released, idle inputs → all controls 0; stall_cnt=flush_cnt=0; scoreboard empty.
- ADDI x5 issued (id_rd_addr=5, wen=1), next cycle id_rs1_addr=5:
  - hold_pc/hold_if_id/flush_id_ex high for exactly 2 cycles with SB_DEPTH=2.
  - stall_cnt=2; the third cycle proceeds with no stall.
- jump_en=1, jump_addr=0x0000_0100 → that cycle jump_en_o=1, jump_addr_o=0x100, both flushes high; next cycle flushes still high; then RUN; flush_cnt=2.
- ext_hold=1 for 3 cycles while a RAW stall is pending → only holds asserted; stall_cnt unchanged; scoreboard frozen. After release the stall resumes for its remaining cycles.
- ext_hold and jump_en both high → no redirect. When ext_hold drops with jump_en still high → redirect occurs that cycle.
- rst pulsed while in FLUSH with a valid scoreboard entry → outputs 0 immediately; no stall for rs1 matching the old rd after release.

Source files
------------

// File: rtl/pipe_ctrl.sv
// Hazard and flush scheduler for the in-order pipeline: redirects, bus freezes,
// post-redirect flush window and RAW stalls against an in-flight rd scoreboard.
module pipe_ctrl #(
  parameter int SB_DEPTH    = 2,
  parameter int FLUSH_EXTRA = 1,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             jump_en,
  input  logic [31:0]      jump_addr,
  input  logic             ext_hold,
  input  logic [4:0]       id_rs1_addr,
  input  logic [4:0]       id_rs2_addr,
  input  logic [4:0]       id_rd_addr,
  input  logic             id_rd_wen,
  output logic             jump_en_o,
  output logic [31:0]      jump_addr_o,
  output logic             hold_pc,
  output logic             hold_if_id,
  output logic             hold_id_ex,
  output logic             flush_if_id,
  output logic             flush_id_ex,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int FC_W = (FLUSH_EXTRA > 1) ? $clog2(FLUSH_EXTRA + 1) : 1;

  typedef enum logic {ST_RUN, ST_FLUSH} state_t;

  state_t           r_state;
  logic [FC_W-1:0]  r_flushLeft;
  logic             r_sbValid [SB_DEPTH];
  logic [4:0]       r_sbRd    [SB_DEPTH];
  logic [CNT_W-1:0] r_stallCnt;
  logic [CNT_W-1:0] r_flushCnt;

  logic w_raw;
  logic w_stall;
  logic w_redirFlush;

  // A source matches any valid in-flight rd, including the entry retiring this cycle.
  always_comb begin
    w_raw = 1'b0;
    for (int i = 0; i < SB_DEPTH; i++) begin
      if (r_sbValid[i] &&
          ((id_rs1_addr != 5'd0 && id_rs1_addr == r_sbRd[i]) ||
           (id_rs2_addr != 5'd0 && id_rs2_addr == r_sbRd[i])))
        w_raw = 1'b1;
    end
  end

  always_comb begin
    jump_en_o    = 1'b0;
    jump_addr_o  = 32'd0;
    hold_pc      = 1'b0;
    hold_if_id   = 1'b0;
    hold_id_ex   = 1'b0;
    flush_if_id  = 1'b0;
    flush_id_ex  = 1'b0;
    w_stall      = 1'b0;
    w_redirFlush = 1'b0;
    if (ext_hold) begin
      hold_pc    = 1'b1;
      hold_if_id = 1'b1;
      hold_id_ex = 1'b1;
    end else if (jump_en) begin
      jump_en_o    = 1'b1;
      jump_addr_o  = jump_addr;
      flush_if_id  = 1'b1;
      flush_id_ex  = 1'b1;
      w_redirFlush = 1'b1;
    end else if (r_state == ST_FLUSH) begin
      flush_if_id  = 1'b1;
      flush_id_ex  = 1'b1;
      w_redirFlush = 1'b1;
    end else if (w_raw) begin
      hold_pc     = 1'b1;
      hold_if_id  = 1'b1;
      flush_id_ex = 1'b1;
      w_stall     = 1'b1;
    end
  end

  // Everything registered is frozen while the bus holds the pipeline.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_RUN;
      r_flushLeft <= '0;
      r_stallCnt  <= '0;
      r_flushCnt  <= '0;
      for (int i = 0; i < SB_DEPTH; i++) begin
        r_sbValid[i] <= 1'b0;
        r_sbRd[i]    <= 5'd0;
      end
    end else if (!ext_hold) begin
      if (jump_en) begin
        if (FLUSH_EXTRA > 0) begin
          r_state     <= ST_FLUSH;
          r_flushLeft <= FC_W'(FLUSH_EXTRA);
        end else begin
          r_state <= ST_RUN;
        end
      end else if (r_state == ST_FLUSH) begin
        r_flushLeft <= r_flushLeft - FC_W'(1);
        if (r_flushLeft <= FC_W'(1))
          r_state <= ST_RUN;
      end
      if (w_stall)
        r_stallCnt <= r_stallCnt + CNT_W'(1);
      if (w_redirFlush)
        r_flushCnt <= r_flushCnt + CNT_W'(1);
      for (int i = SB_DEPTH - 1; i > 0; i--) begin
        r_sbValid[i] <= r_sbValid[i-1];
        r_sbRd[i]    <= r_sbRd[i-1];
      end
      r_sbValid[0] <= id_rd_wen && (id_rd_addr != 5'd0) && !flush_id_ex;
      r_sbRd[0]    <= id_rd_addr;
    end
  end

  assign stall_cnt = r_stallCnt;
  assign flush_cnt = r_flushCnt;

endmodule
